// File: rtl/vector_pkg.sv
// Shared constants, occupancy states and payload type for the Execute->Memory vector buffer.
// The VEX_LANE_MASK_EN macro adds a per-lane mask field to the payload.
package vector_pkg;

    localparam int VEC_DATA_WIDTH = 8;
    localparam int VEC_LANES      = 6;
    localparam int VEC_REG_ADDR_W = 4;

    // The encoding is {main_v, skid_v}, so the slot valids read straight off the state bits.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b10,
        BUF_FULL  = 2'b11
    } buf_state_e;

    typedef struct packed {
        logic [VEC_DATA_WIDTH*VEC_LANES-1:0] result;
        logic [VEC_REG_ADDR_W-1:0]           rd;
        logic                                wb_en;
        logic                                mem_we;
`ifdef VEX_LANE_MASK_EN
        logic [VEC_LANES-1:0]                lane_mask;
`endif
    } ex_mem_payload_t;

endpackage

// File: rtl/vex_payload_slot.sv
// One payload register. Clearing drops only the enables (and restores the mask); data is kept.
// The VEX_LANE_MASK_EN macro enables the lane_mask field handling.
module vex_payload_slot
    import vector_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            clr_i,
    input  ex_mem_payload_t d_i,
    output ex_mem_payload_t q_o
);

    ex_mem_payload_t slot_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
`ifdef VEX_LANE_MASK_EN
            slot_q.lane_mask <= '1;
`endif
        end else if (clr_i) begin
            slot_q.wb_en  <= 1'b0;
            slot_q.mem_we <= 1'b0;
`ifdef VEX_LANE_MASK_EN
            slot_q.lane_mask <= '1;
`endif
        end else if (load_i) begin
            slot_q <= d_i;
        end
    end

    assign q_o = slot_q;

endmodule

// File: rtl/vector_ex_mem_buffer.sv
// Two-entry skid buffer between the vector ALU and the Memory stage; in_ready comes from a flop.
// The VEX_LANE_MASK_EN macro adds in_lane_mask/out_lane_mask and zeroes the masked-off lanes.
module vector_ex_mem_buffer
    import vector_pkg::*;
#(
    parameter int DATA_WIDTH = VEC_DATA_WIDTH,
    parameter int LANES      = VEC_LANES,
    parameter int REG_ADDR_W = VEC_REG_ADDR_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH*LANES-1:0] in_result,
    input  logic [REG_ADDR_W-1:0]       in_rd,
    input  logic                        in_wb_en,
    input  logic                        in_mem_we,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH*LANES-1:0] out_result,
    output logic [REG_ADDR_W-1:0]       out_rd,
    output logic                        out_wb_en,
    output logic                        out_mem_we
`ifdef VEX_LANE_MASK_EN
   ,input  logic [LANES-1:0]            in_lane_mask
   ,output logic [LANES-1:0]            out_lane_mask
`endif
);

    buf_state_e      state_q, state_d;
    ex_mem_payload_t in_pl, main_d, main_q, skid_q;
    logic            main_ld, skid_ld, accept, pop;

    always_comb begin
        in_pl        = '0;
        in_pl.result = in_result;
        in_pl.rd     = in_rd;
        in_pl.wb_en  = in_wb_en;
        in_pl.mem_we = in_mem_we;
`ifdef VEX_LANE_MASK_EN
        in_pl.lane_mask = in_lane_mask;
`endif
    end

    assign in_ready  = ~state_q[0];
    assign out_valid = state_q[1];
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= BUF_EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        main_ld = 1'b0;
        skid_ld = 1'b0;
        main_d  = in_pl;
        if (flush) begin
            state_d = BUF_EMPTY;
        end else begin
            case (state_q)
                BUF_EMPTY: if (accept) begin
                    main_ld = 1'b1;
                    state_d = BUF_ONE;
                end
                BUF_ONE: begin
                    if (accept && pop) begin
                        main_ld = 1'b1;
                    end else if (accept) begin
                        skid_ld = 1'b1;
                        state_d = BUF_FULL;
                    end else if (pop) begin
                        state_d = BUF_EMPTY;
                    end
                end
                BUF_FULL: if (pop) begin
                    main_ld = 1'b1;
                    main_d  = skid_q;
                    state_d = BUF_ONE;
                end
                default: state_d = BUF_EMPTY;
            endcase
        end
    end

    vex_payload_slot u_main (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (main_ld),
        .clr_i  (flush),
        .d_i    (main_d),
        .q_o    (main_q)
    );

    vex_payload_slot u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (skid_ld),
        .clr_i  (flush),
        .d_i    (in_pl),
        .q_o    (skid_q)
    );

    assign out_rd     = main_q.rd;
    assign out_wb_en  = main_q.wb_en;
    assign out_mem_we = main_q.mem_we;
`ifdef VEX_LANE_MASK_EN
    assign out_lane_mask = main_q.lane_mask;
`endif

    // The mask is packed like the result: the bit in a lane's position governs that lane.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int LSB = (LANES - 1 - i) * DATA_WIDTH;
`ifdef VEX_LANE_MASK_EN
        assign out_result[LSB +: DATA_WIDTH] =
            main_q.lane_mask[LANES-1-i] ? main_q.result[LSB +: DATA_WIDTH] : '0;
`else
        assign out_result[LSB +: DATA_WIDTH] = main_q.result[LSB +: DATA_WIDTH];
`endif
    end

endmodule
